// File: rtl/reg_file_if.sv
// Register-file port bundle: two read ports and one write port.
// Decode drives the addresses and write-back drives the write controls.
interface reg_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] ReadAddr1;
    logic [ADDR_WIDTH-1:0] ReadAddr2;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [ADDR_WIDTH-1:0] WriteAddr;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;

    modport master (
        output ReadAddr1, ReadAddr2, WriteAddr, WriteData, RegWrite,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  ReadAddr1, ReadAddr2, WriteAddr, WriteData, RegWrite,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/reg_file.sv
// 2^ADDR_WIDTH x DATA_WIDTH register file: two combinational read ports, one synchronous write port.
// Register 0 always reads as zero, and writes to it are dropped.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    reg_file_if.slave   bus
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NREGS];
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    assign w_wr_en = bus.RegWrite && (bus.WriteAddr != '0);

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.WriteAddr] <= bus.WriteData;
        end
    end

    // No write bypass: reads show the pre-edge contents.
    assign w_rd1 = (bus.ReadAddr1 == '0) ? '0 : r_regs[bus.ReadAddr1];
    assign w_rd2 = (bus.ReadAddr2 == '0) ? '0 : r_regs[bus.ReadAddr2];

    assign bus.ReadData1 = w_rd1;
    assign bus.ReadData2 = w_rd2;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand-written corner sequences,
// and randomized traffic checked against an array model.
module tb_reg_file;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bit [31:0] model [32];

    reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bif ();

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] model_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    // Drive write/reset controls at the falling edge, take one rising edge, update model.
    task automatic apply_edge(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        rst_n         = r;
        bif.RegWrite  = we;
        bif.WriteAddr = wa;
        bif.WriteData = wd;
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
        #1;
        bif.RegWrite = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [31:0] e1, input logic [31:0] e2);
        bif.ReadAddr1 = a1;
        bif.ReadAddr2 = a2;
        #1;
        chk({name, "_rd1"}, bif.ReadData1, e1);
        chk({name, "_rd2"}, bif.ReadData2, e2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bif.RegWrite  = 1'b0;
        bif.WriteAddr = '0;
        bif.WriteData = '0;
        bif.ReadAddr1 = '0;
        bif.ReadAddr2 = '0;

        //           rst  we  wa     wd            ra1    ra2    exp1          exp2
        vecs[0] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0,  5'd1,  32'h0,        32'h0};
        vecs[1] = '{1'b1, 1'b0, 5'd0, 32'h0,        5'd31, 5'd31, 32'h0,        32'h0};
        vecs[2] = '{1'b1, 1'b1, 5'd1, 32'hA5A5A5A5, 5'd1,  5'd0,  32'hA5A5A5A5, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0,  5'd1,  32'h0,        32'hA5A5A5A5};
        vecs[4] = '{1'b1, 1'b0, 5'd2, 32'h12345678, 5'd2,  5'd2,  32'h0,        32'h0};
        vecs[5] = '{1'b1, 1'b1, 5'd5, 32'h11111111, 5'd5,  5'd1,  32'h11111111, 32'hA5A5A5A5};
        vecs[6] = '{1'b1, 1'b1, 5'd6, 32'h22222222, 5'd5,  5'd6,  32'h11111111, 32'h22222222};
        vecs[7] = '{1'b0, 1'b1, 5'd5, 32'hFFFFFFFF, 5'd5,  5'd6,  32'h0,        32'h0};
        vecs[8] = '{1'b1, 1'b0, 5'd0, 32'h0,        5'd1,  5'd6,  32'h0,        32'h0};

        for (int v = 0; v < 9; v++) begin
            apply_edge(vecs[v].rst_n, vecs[v].we, vecs[v].wa, vecs[v].wd);
            read_chk($sformatf("vec%0d", v), vecs[v].ra1, vecs[v].ra2, vecs[v].exp1, vecs[v].exp2);
        end

        // Same-cycle read of the register being written: old value before the edge, new after.
        @(negedge clk);
        bif.RegWrite  = 1'b1;
        bif.WriteAddr = 5'd3;
        bif.WriteData = 32'hCAFEF00D;
        bif.ReadAddr1 = 5'd3;
        bif.ReadAddr2 = 5'd3;
        #1;
        chk("nobypass_rd1", bif.ReadData1, 32'h0);
        chk("nobypass_rd2", bif.ReadData2, 32'h0);
        @(posedge clk);
        model[3] = 32'hCAFEF00D;
        #1;
        bif.RegWrite = 1'b0;
        chk("postedge_rd1", bif.ReadData1, 32'hCAFEF00D);
        chk("postedge_rd2", bif.ReadData2, 32'hCAFEF00D);

        // Sweep every register, then read all back on both ports.
        for (int i = 1; i < 32; i++) begin
            apply_edge(1'b1, 1'b1, 5'(i), 32'h100 + 32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            read_chk($sformatf("sweep%0d", i), 5'(i), 5'(31 - i),
                     (i == 0) ? 32'h0 : 32'h100 + 32'(i),
                     (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i));
        end

        // Randomized traffic: reads checked before each edge against the model.
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        we;
            logic [4:0]  wa;
            logic [31:0] wd;
            r  = ($urandom_range(0, 39) != 0);
            we = $urandom_range(0, 1) == 1;
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            @(negedge clk);
            rst_n         = r;
            bif.RegWrite  = we;
            bif.WriteAddr = wa;
            bif.WriteData = wd;
            bif.ReadAddr1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            bif.ReadAddr2 = 5'($urandom_range(0, 31));
            #1;
            chk($sformatf("rnd%0d_rd1", n), bif.ReadData1, model_rd(bif.ReadAddr1));
            chk($sformatf("rnd%0d_rd2", n), bif.ReadData2, model_rd(bif.ReadAddr2));
            @(posedge clk);
            if (!r) begin
                for (int i = 0; i < 32; i++) model[i] = 32'd0;
            end else if (we && wa != 5'd0) begin
                model[wa] = wd;
            end
        end

        @(negedge clk);
        rst_n = 1'b1;
        bif.RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_chk($sformatf("final%0d", i), 5'(i), 5'(i), model_rd(5'(i)), model_rd(5'(i)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
